// File: rtl/grid_pkg.sv
// Shared state encoding, grid size defaults and score table for the grid line-clear engine.
package grid_pkg;

   localparam int GRID_ROWS = 20;
   localparam int GRID_COLS = 10;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EVAL,
      WRITE,
      CLEAR,
      DONE
   } clear_state_t;

   localparam logic [15:0] SCORE_NONE  = 16'd0;
   localparam logic [15:0] SCORE_ONE   = 16'd40;
   localparam logic [15:0] SCORE_TWO   = 16'd100;
   localparam logic [15:0] SCORE_THREE = 16'd300;
   localparam logic [15:0] SCORE_FOUR  = 16'd1200;

   // Four or more lines in one pass all earn the top award.
   function automatic logic [15:0] scoreFor(input logic [4:0] lines);
      logic [15:0] score;
      case (lines)
         5'd0:    score = SCORE_NONE;
         5'd1:    score = SCORE_ONE;
         5'd2:    score = SCORE_TWO;
         5'd3:    score = SCORE_THREE;
         default: score = SCORE_FOUR;
      endcase
      return score;
   endfunction

endpackage

// File: rtl/grid_row_buffer.sv
// One-row staging buffer: captures the cells of the row being read, tracks whether
// every captured cell is occupied, and muxes a cell back out for the write-back.
module grid_row_buffer
   import grid_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int COLS       = GRID_COLS,
   parameter int IDX_W      = $clog2(COLS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init,
   input  logic                  capture,
   input  logic [IDX_W-1:0]      captureIdx,
   input  logic [DATA_WIDTH-1:0] captureData,
   input  logic [IDX_W-1:0]      readIdx,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  rowFull
);

   logic [DATA_WIDTH-1:0] cells [COLS];

   // rowFull starts optimistic at the top of each row and is knocked down by any empty cell.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rowFull <= 1'b0;
         for (int i = 0; i < COLS; i++) begin
            cells[i] <= '0;
         end
      end else if (init) begin
         rowFull <= 1'b1;
      end else if (capture) begin
         cells[captureIdx] <= captureData;
         rowFull           <= rowFull & (captureData != '0);
      end
   end

   assign readData = cells[readIdx];

endmodule

// File: rtl/grid_line_clear.sv
// Scans the game grid bottom-up, drops full rows, compacts survivors downward and
// zero-fills the top. Define GRID_LINE_CLEAR_SCORE_EN to add the scoreDelta output.
module grid_line_clear
   import grid_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int GRID_BASE     = 0,
   parameter int COLS          = GRID_COLS,
   parameter int ROWS          = GRID_ROWS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [4:0]               linesCleared,
   output logic                     memWEn,
   output logic [ADDRESS_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0]    memDataOut,
   input  logic [DATA_WIDTH-1:0]    memDataIn
`ifdef GRID_LINE_CLEAR_SCORE_EN
   ,
   output logic [15:0]              scoreDelta
`endif
);

   localparam int SRC_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(ROWS * COLS + 1);
   localparam int IDX_W = $clog2(COLS);

   localparam logic [SRC_W-1:0] LAST_ROW  = SRC_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] COL_COUNT = CNT_W'(COLS);
   localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(COLS - 1);

   if (64'(GRID_BASE) + 64'(ROWS) * 64'(COLS) > (64'd1 << ADDRESS_WIDTH)) begin : g_range_check
      $error("grid_line_clear: GRID_BASE + ROWS*COLS exceeds the address space");
   end

   clear_state_t state, stateNext;
   logic [CNT_W-1:0]      cnt, cntNext;
   logic [SRC_W-1:0]      src, srcNext;
   logic [SRC_W-1:0]      dst, dstNext;
   logic [4:0]            clearedNext;
   logic                  busyNext;
   logic                  nextRow;
   logic                  rowInit;
   logic                  capture;
   logic                  rowFull;
   logic [DATA_WIDTH-1:0] readData;
   logic [CNT_W-1:0]      clearEnd;

   logic                     memWEnNext;
   logic [ADDRESS_WIDTH-1:0] memAddrNext;
   logic [DATA_WIDTH-1:0]    memDataNext;

   function automatic logic [ADDRESS_WIDTH-1:0] cellAddr(input logic [SRC_W-1:0] row,
                                                         input logic [CNT_W-1:0] col);
      return ADDRESS_WIDTH'(GRID_BASE) + ADDRESS_WIDTH'(row) * ADDRESS_WIDTH'(COLS)
             + ADDRESS_WIDTH'(col);
   endfunction

   assign clearEnd = CNT_W'(linesCleared) * COL_COUNT - CNT_W'(1);

   grid_row_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .COLS       (COLS),
      .IDX_W      (IDX_W)
   ) u_row_buffer (
      .clk         (clk),
      .rst_n       (rst_n),
      .init        (rowInit),
      .capture     (capture),
      .captureIdx  (IDX_W'(cnt - CNT_W'(1))),
      .captureData (memDataIn),
      .readIdx     (IDX_W'(cntNext)),
      .readData    (readData),
      .rowFull     (rowFull)
   );

   // Sequencing: each row is read (data lags the address by one cycle), judged, and
   // either discarded, left in place, or written down to the current destination row.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      srcNext     = src;
      dstNext     = dst;
      clearedNext = linesCleared;
      busyNext    = busy;
      nextRow     = 1'b0;
      capture     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               stateNext   = READ;
               cntNext     = '0;
               srcNext     = LAST_ROW;
               dstNext     = LAST_ROW;
               clearedNext = '0;
               busyNext    = 1'b1;
            end
         end
         READ: begin
            capture = (cnt != '0);
            if (cnt == COL_COUNT) begin
               stateNext = EVAL;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         EVAL: begin
            if (rowFull) begin
               clearedNext = linesCleared + 5'd1;
               nextRow     = 1'b1;
            end else if (src != dst) begin
               stateNext = WRITE;
               cntNext   = '0;
            end else begin
               dstNext = dst - SRC_W'(1);
               nextRow = 1'b1;
            end
         end
         WRITE: begin
            if (cnt == LAST_COL) begin
               dstNext = dst - SRC_W'(1);
               nextRow = 1'b1;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         CLEAR: begin
            if (cnt == clearEnd) begin
               stateNext = DONE;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            stateNext = IDLE;
            busyNext  = 1'b0;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      // Moving to the row above, or finishing the scan once the top row is handled.
      if (nextRow) begin
         cntNext = '0;
         if (src == '0) begin
            stateNext = (clearedNext == '0) ? DONE : CLEAR;
         end else begin
            srcNext   = src - SRC_W'(1);
            stateNext = READ;
         end
      end

      rowInit = (stateNext == READ) && (state != READ);
   end

   // RAM port values are staged from the next state so the port itself is purely registered.
   always_comb begin
      memWEnNext  = (stateNext == WRITE) || (stateNext == CLEAR);
      memAddrNext = memAddr;
      memDataNext = '0;
      case (stateNext)
         READ: begin
            if (cntNext < COL_COUNT) begin
               memAddrNext = cellAddr(srcNext, cntNext);
            end
         end
         WRITE: begin
            memAddrNext = cellAddr(dstNext, cntNext);
            memDataNext = readData;
         end
         CLEAR: begin
            memAddrNext = ADDRESS_WIDTH'(GRID_BASE) + ADDRESS_WIDTH'(cntNext);
         end
         default: begin
            memAddrNext = memAddr;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         src          <= '0;
         dst          <= '0;
         linesCleared <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         memWEn       <= 1'b0;
         memAddr      <= '0;
         memDataOut   <= '0;
      end else begin
         state        <= stateNext;
         cnt          <= cntNext;
         src          <= srcNext;
         dst          <= dstNext;
         linesCleared <= clearedNext;
         busy         <= busyNext;
         done         <= (stateNext == DONE);
         memWEn       <= memWEnNext;
         memAddr      <= memAddrNext;
         memDataOut   <= memDataNext;
      end
   end

`ifdef GRID_LINE_CLEAR_SCORE_EN
   // The award is latched as the pass completes and then held for the caller.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scoreDelta <= '0;
      end else if (stateNext == DONE) begin
         scoreDelta <= scoreFor(clearedNext);
      end
   end
`endif

endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: RAM model plus a table of grid images with hand-computed results.
module tb_grid_line_clear;

   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int BASE  = 40;
   localparam int COLS  = 10;
   localparam int ROWS  = 20;
   localparam int LIMIT = 3000;
   localparam logic [DW-1:0] SENTINEL = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic [4:0]    linesCleared;
   logic          memWEn;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memDataOut;
   logic [DW-1:0] memDataIn;
`ifdef GRID_LINE_CLEAR_SCORE_EN
   logic [15:0]   scoreDelta;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int writeCount  = 0;

   logic [DW-1:0] ram   [0:(1<<AW)-1];
   logic [DW-1:0] image [0:(1<<AW)-1];
   logic          loadPending = 1'b0;

   typedef struct {
      logic [19:0]   full;
      int            hole;
      int            s0r; int s0c; logic [31:0] s0v;
      int            s1r; int s1c; logic [31:0] s1v;
      bit            keep;
      int            lines; int cycles; int writes;
      int            e0r; int e0c; logic [31:0] e0v;
      int            e1r; int e1c; logic [31:0] e1v;
      int            score;
   } vec_t;

   vec_t vecs [8];

   grid_line_clear #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .GRID_BASE     (BASE),
      .COLS          (COLS),
      .ROWS          (ROWS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .linesCleared (linesCleared),
      .memWEn       (memWEn),
      .memAddr      (memAddr),
      .memDataOut   (memDataOut),
      .memDataIn    (memDataIn)
`ifdef GRID_LINE_CLEAR_SCORE_EN
      ,
      .scoreDelta   (scoreDelta)
`endif
   );

   always #5 clk = ~clk;

   // Single-port RAM: one-cycle read latency, output frozen while writing.
   always @(posedge clk) begin
      if (loadPending) begin
         for (int a = 0; a < (1 << AW); a++) begin
            ram[a] = image[a];
         end
      end else if (memWEn === 1'b1) begin
         ram[memAddr] = memDataOut;
      end else begin
         memDataIn <= ram[memAddr];
      end
   end

   always @(posedge clk) begin
      if (memWEn === 1'b1) writeCount++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   function automatic logic [31:0] initCell(input vec_t v, input int r, input int c);
      logic [31:0] val;
      val = '0;
      if (v.full[r]) val = 32'(r * COLS + c + 1);
      if (r == v.hole) val = (c == COLS - 1) ? 32'h0 : 32'h3;
      if (r == v.s0r && c == v.s0c) val = v.s0v;
      if (r == v.s1r && c == v.s1c) val = v.s1v;
      return val;
   endfunction

   function automatic logic [31:0] expCell(input vec_t v, input int r, input int c);
      logic [31:0] val;
      if (v.keep) return initCell(v, r, c);
      val = '0;
      if (r == v.e0r && c == v.e0c) val = v.e0v;
      if (r == v.e1r && c == v.e1c) val = v.e1v;
      return val;
   endfunction

   task automatic loadGrid(input vec_t v);
      for (int a = 0; a < (1 << AW); a++) image[a] = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            image[BASE + r * COLS + c] = initCell(v, r, c);
         end
      end
      image[BASE - 1]           = SENTINEL;
      image[BASE + ROWS * COLS] = SENTINEL;
      @(negedge clk) loadPending = 1'b1;
      @(posedge clk);
      #1 loadPending = 1'b0;
   endtask

   // Pulses start and counts edges from the accept edge (counted as 1) to done high.
   task automatic runPass(output int cyc, output bit ok);
      ok = 1'b0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      while (cyc < LIMIT) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      int   cyc;
      bit   ok;
      int   bad;
      int   wrBefore;
      v = vecs[idx];
      loadGrid(v);
      wrBefore = writeCount;
      runPass(cyc, ok);
      checkOutput($sformatf("v%0d done seen", idx), 32'(ok), 32'd1);
      checkOutput($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.cycles));
      checkOutput($sformatf("v%0d busy with done", idx), 32'(busy), 32'd1);
      checkOutput($sformatf("v%0d linesCleared", idx), 32'(linesCleared), 32'(v.lines));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d busy released", idx), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d write count", idx), 32'(writeCount - wrBefore), 32'(v.writes));
`ifdef GRID_LINE_CLEAR_SCORE_EN
      checkOutput($sformatf("v%0d scoreDelta", idx), 32'(scoreDelta), 32'(v.score));
`endif
      bad = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (ram[BASE + r * COLS + c] !== expCell(v, r, c)) bad++;
         end
      end
      checkOutput($sformatf("v%0d grid bad cells", idx), 32'(bad), 32'd0);
      checkOutput($sformatf("v%0d low sentinel", idx), ram[BASE - 1], SENTINEL);
      checkOutput($sformatf("v%0d high sentinel", idx), ram[BASE + ROWS * COLS], SENTINEL);
   endtask

   initial begin
      int n;
      int doneCount;
      int firstDone;
      int wrBefore;

      //          full      hole  s0 (r,c,v)        s1 (r,c,v)        keep lines cyc  wr   e0 (r,c,v)        e1 (r,c,v)        score
      vecs[0] = '{20'h00000, -1,  -1, 0, 32'h0,     -1, 0, 32'h0,     1'b0, 0, 241,   0,  -1, 0, 32'h0,     -1, 0, 32'h0,        0};
      vecs[1] = '{20'h80000, -1,  18, 0, 32'h7,     -1, 0, 32'h0,     1'b0, 1, 441, 200,  19, 0, 32'h7,     -1, 0, 32'h0,       40};
      vecs[2] = '{20'hA0000, -1,  18, 3, 32'h5,     -1, 0, 32'h0,     1'b0, 2, 441, 200,  19, 3, 32'h5,     -1, 0, 32'h0,      100};
      vecs[3] = '{20'hF0000, -1,  -1, 0, 32'h0,     -1, 0, 32'h0,     1'b0, 4, 441, 200,  -1, 0, 32'h0,     -1, 0, 32'h0,     1200};
      vecs[4] = '{20'h00000, 19,  -1, 0, 32'h0,     -1, 0, 32'h0,     1'b1, 0, 241,   0,  -1, 0, 32'h0,     -1, 0, 32'h0,        0};
      vecs[5] = '{20'h00001, -1,  19, 5, 32'h9,     -1, 0, 32'h0,     1'b0, 1, 251,  10,  19, 5, 32'h9,     -1, 0, 32'h0,       40};
      vecs[6] = '{20'h80400, -1,  15, 4, 32'hABCD,   5, 9, 32'h1234,  1'b0, 2, 441, 200,  16, 4, 32'hABCD,   7, 9, 32'h1234,  100};
      vecs[7] = '{20'hFFFFF, -1,  -1, 0, 32'h0,     -1, 0, 32'h0,     1'b0,20, 441, 200,  -1, 0, 32'h0,     -1, 0, 32'h0,     1200};

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset linesCleared", 32'(linesCleared), 32'd0);
      checkOutput("reset memWEn", 32'(memWEn), 32'd0);
      checkOutput("reset memAddr", 32'(memAddr), 32'd0);
      checkOutput("reset memDataOut", memDataOut, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(i);
      end

      // A start raised mid-pass must not restart or extend the pass.
      loadGrid(vecs[4]);
      wrBefore = writeCount;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1;
      doneCount = 0;
      firstDone = 0;
      while (n < 600) begin
         if (done === 1'b1) begin
            doneCount++;
            if (firstDone == 0) firstDone = n;
         end
         start = (n == 50 || n == 200) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      checkOutput("busy start done count", 32'(doneCount), 32'd1);
      checkOutput("busy start latency", 32'(firstDone), 32'd241);
      checkOutput("busy start writes", 32'(writeCount - wrBefore), 32'd0);
      checkOutput("busy start idle", 32'(busy), 32'd0);

      // Reset asserted during the write-back phase.
      loadGrid(vecs[1]);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (memWEn !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("midreset write reached", 32'(memWEn === 1'b1), 32'd1);
      checkOutput("midreset lines before", 32'(linesCleared), 32'd1);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset memWEn", 32'(memWEn), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset linesCleared", 32'(linesCleared), 32'd0);
      checkOutput("midreset done", 32'(done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
